// File: rtl/matrix_win_gen_if.sv
// Video-in / window-out bundle for matrix_win_gen.
// With MATRIX_WIN_COORD_EN defined the bundle also carries the window-centre coordinates.
interface matrix_win_gen_if #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3
);
  logic                            pre_vs;
  logic                            pre_de;
  logic [DATA_W-1:0]               pre_data;
  logic                            win_vs;
  logic                            win_de;
  logic [KSIZE*KSIZE*DATA_W-1:0]   win_data;
`ifdef MATRIX_WIN_COORD_EN
  logic [11:0]                     win_x;
  logic [11:0]                     win_y;

  modport master (output pre_vs, pre_de, pre_data,
                  input  win_vs, win_de, win_data, win_x, win_y);
  modport slave  (input  pre_vs, pre_de, pre_data,
                  output win_vs, win_de, win_data, win_x, win_y);
`else
  modport master (output pre_vs, pre_de, pre_data,
                  input  win_vs, win_de, win_data);
  modport slave  (input  pre_vs, pre_de, pre_data,
                  output win_vs, win_de, win_data);
`endif
endinterface

// File: rtl/matrix_win_gen.sv
// KSIZE x KSIZE sliding-window generator over a raster pixel stream, line buffers in block RAM.
// Optional feature macro MATRIX_WIN_COORD_EN adds win_x/win_y (window centre) outputs.
module matrix_win_gen #(
  parameter int DATA_W    = 8,
  parameter int KSIZE     = 3,
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720
) (
  input  logic            clk,
  input  logic            rst_n,
  matrix_win_gen_if.slave bus
);
  localparam int NB = KSIZE - 1;
  localparam int R  = (KSIZE - 1) / 2;
  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int RW = $clog2(IMG_VDISP + 1);
  localparam int WW = KSIZE * KSIZE * DATA_W;
  localparam logic [CW-1:0] COL_END = CW'(IMG_HDISP);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_VDISP);
  localparam logic [CW-1:0] COL_MIN = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_MIN = RW'(KSIZE - 1);

  logic          vs_d1_reg;
  logic          vs_d2_reg;
  logic          de_d_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          vs_rise;
  logic          line_end;
  logic          accept;
  logic          emit;
  logic [AW-1:0] addr;

  // A pre_de drop before the line is full is a stall, not the end of the line.
  assign vs_rise  = bus.pre_vs & ~vs_d1_reg;
  assign line_end = de_d_reg & ~bus.pre_de & (col_reg == COL_END);
  assign accept   = bus.pre_de & (col_reg < COL_END) & (row_reg < ROW_END);
  assign emit     = accept & (col_reg >= COL_MIN) & (row_reg >= ROW_MIN);
  assign addr     = col_reg[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_reg <= 1'b0;
      vs_d2_reg <= 1'b0;
      de_d_reg  <= 1'b0;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      vs_d1_reg <= bus.pre_vs;
      vs_d2_reg <= vs_d1_reg;
      de_d_reg  <= bus.pre_de;
      if (vs_rise) begin
        col_reg <= '0;
        row_reg <= '0;
      end else if (accept) begin
        col_reg <= col_reg + 1'b1;
      end else if (line_end) begin
        col_reg <= '0;
        if (row_reg < ROW_END)
          row_reg <= row_reg + 1'b1;
      end
    end
  end

  logic              acc_s1_reg;
  logic              emit_s1_reg;
  logic              acc_s2_reg;
  logic              emit_s2_reg;
  logic [DATA_W-1:0] pix_s1_reg;
  logic [AW-1:0]     col_s1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s1_reg  <= 1'b0;
      emit_s1_reg <= 1'b0;
      acc_s2_reg  <= 1'b0;
      emit_s2_reg <= 1'b0;
      pix_s1_reg  <= '0;
      col_s1_reg  <= '0;
    end else begin
      acc_s1_reg  <= accept;
      emit_s1_reg <= emit;
      acc_s2_reg  <= acc_s1_reg;
      emit_s2_reg <= emit_s1_reg;
      if (accept) begin
        pix_s1_reg <= bus.pre_data;
        col_s1_reg <= addr;
      end
    end
  end

  // Buffer gi holds line row-(gi+1); each buffer is refilled one cycle late from its
  // predecessor's registered read so every RAM keeps a single read and write port.
  logic [DATA_W-1:0] lb_rd [NB];

  genvar gi;
  genvar gj;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lb
      logic [DATA_W-1:0] mem [IMG_HDISP];
      logic [DATA_W-1:0] rd_reg;
      logic [DATA_W-1:0] wr_data;
      logic [AW-1:0]     wr_addr;
      logic              wr_en;

      if (gi == 0) begin : g_head
        assign wr_en   = accept;
        assign wr_addr = addr;
        assign wr_data = bus.pre_data;
      end else begin : g_chain
        assign wr_en   = acc_s1_reg;
        assign wr_addr = col_s1_reg;
        assign wr_data = lb_rd[gi-1];
      end

      always_ff @(posedge clk) begin
        if (wr_en)
          mem[wr_addr] <= wr_data;
        if (accept)
          rd_reg <= mem[addr];
      end

      assign lb_rd[gi] = rd_reg;
    end
  endgenerate

  logic [WW-1:0] win_cur;

  generate
    for (gi = 0; gi < KSIZE; gi++) begin : g_row
      logic [DATA_W-1:0] taps [KSIZE];
      logic [DATA_W-1:0] load;

      // Bottom window row is the live pixel; row gi above it comes from buffer KSIZE-2-gi.
      if (gi == KSIZE - 1) begin : g_live
        assign load = pix_s1_reg;
      end else begin : g_buf
        assign load = lb_rd[KSIZE-2-gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < KSIZE; j++)
            taps[j] <= '0;
        end else if (acc_s1_reg) begin
          for (int j = 0; j < KSIZE - 1; j++)
            taps[j] <= taps[j+1];
          taps[KSIZE-1] <= load;
        end
      end

      for (gj = 0; gj < KSIZE; gj++) begin : g_col
        assign win_cur[(gi*KSIZE+gj)*DATA_W +: DATA_W] = taps[gj];
      end
    end
  endgenerate

  logic          win_de_reg;
  logic [WW-1:0] win_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_de_reg   <= 1'b0;
      win_data_reg <= '0;
    end else begin
      win_de_reg <= emit_s2_reg;
      if (acc_s2_reg)
        win_data_reg <= win_cur;
    end
  end

  assign bus.win_vs   = vs_d2_reg;
  assign bus.win_de   = win_de_reg;
  assign bus.win_data = win_data_reg;

`ifdef MATRIX_WIN_COORD_EN
  logic [RW-1:0] row_s1_reg;
  logic [RW-1:0] row_s2_reg;
  logic [AW-1:0] col_s2_reg;
  logic [11:0]   win_x_reg;
  logic [11:0]   win_y_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_reg <= '0;
      row_s2_reg <= '0;
      col_s2_reg <= '0;
      win_x_reg  <= '0;
      win_y_reg  <= '0;
    end else begin
      if (accept)
        row_s1_reg <= row_reg;
      if (acc_s1_reg) begin
        col_s2_reg <= col_s1_reg;
        row_s2_reg <= row_s1_reg;
      end
      // Newest pixel is the bottom-right corner, so the centre trails it by R in both axes.
      if (emit_s2_reg) begin
        win_x_reg <= 12'(col_s2_reg) - 12'(R);
        win_y_reg <= 12'(row_s2_reg) - 12'(R);
      end
    end
  end

  assign bus.win_x = win_x_reg;
  assign bus.win_y = win_y_reg;
`endif

endmodule

// File: tb/tb_matrix_win_gen.sv
// Bench for matrix_win_gen: KSIZE=3 and KSIZE=5 instances share one 8x6 pixel stream and are
// checked against a window model computed directly from the image raster.
`timescale 1ns/1ps
module tb_matrix_win_gen;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pre_vs = 1'b0;
  logic       pre_de = 1'b0;
  logic [7:0] pre_data = 8'd0;

  always #5 clk = ~clk;

  matrix_win_gen_if #(.DATA_W(DW), .KSIZE(3)) bus3 ();
  matrix_win_gen_if #(.DATA_W(DW), .KSIZE(5)) bus5 ();

  assign bus3.pre_vs   = pre_vs;
  assign bus3.pre_de   = pre_de;
  assign bus3.pre_data = pre_data;
  assign bus5.pre_vs   = pre_vs;
  assign bus5.pre_de   = pre_de;
  assign bus5.pre_data = pre_data;

  matrix_win_gen #(.DATA_W(DW), .KSIZE(3), .IMG_HDISP(H), .IMG_VDISP(V)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  matrix_win_gen #(.DATA_W(DW), .KSIZE(5), .IMG_HDISP(H), .IMG_VDISP(V)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  typedef struct {
    int           cyc;
    logic [199:0] data;
    int           x;
    int           y;
  } win_t;

  win_t exp3[$];
  win_t exp5[$];
  win_t obs3[$];
  win_t obs5[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every window strobe with the cycle it became visible.
  always @(negedge clk) begin
    win_t w;
    if (bus3.win_de === 1'b1) begin
      w.cyc = cyc; w.data = 200'(bus3.win_data); w.x = 0; w.y = 0;
`ifdef MATRIX_WIN_COORD_EN
      w.x = int'(bus3.win_x); w.y = int'(bus3.win_y);
`endif
      obs3.push_back(w);
    end
    if (bus5.win_de === 1'b1) begin
      w.cyc = cyc; w.data = 200'(bus5.win_data); w.x = 0; w.y = 0;
      obs5.push_back(w);
    end
  end

  function automatic logic [7:0] pix(int r, int c, int off);
    return 8'((r * 16 + c + off) & 255);
  endfunction

  // Window whose bottom-right pixel is (r,c); visible two edges after the capture edge.
  function automatic win_t model_win(int k, int r, int c, int off, int cap);
    win_t w;
    w.data = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        w.data[(i*k+j)*8 +: 8] = pix(r - (k-1) + i, c - (k-1) + j, off);
    w.cyc = cap + 2;
    w.x   = c - (k-1)/2;
    w.y   = r - (k-1)/2;
    return w;
  endfunction

  task automatic drive(input logic vs, input logic de, input logic [7:0] d);
    @(posedge clk); #1;
    pre_vs = vs; pre_de = de; pre_data = d;
  endtask

  task automatic clear_queues();
    exp3.delete(); exp5.delete(); obs3.delete(); obs5.delete();
  endtask

  task automatic drive_pixel(input int r, input int c, input int off);
    drive(1'b0, 1'b1, pix(r, c, off));
    if (c < H && r < V) begin
      if (c >= 2 && r >= 2) exp3.push_back(model_win(3, r, c, off, cyc + 1));
      if (c >= 4 && r >= 4) exp5.push_back(model_win(5, r, c, off, cyc + 1));
    end
  endtask

  task automatic run_frame(input int line_len, input bit stall, input int nrows,
                           input bit tail_gap, input int off);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < line_len; c++) begin
        if (stall && c > 0 && $urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 8'($urandom));
        drive_pixel(r, c, off);
      end
      if (tail_gap || r < nrows - 1)
        repeat (3) drive(1'b0, 1'b0, 8'd0);
    end
  endtask

  task automatic drain();
    repeat (6) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus3.win_vs !== 1'b0 || bus3.win_de !== 1'b0 || bus3.win_data !== '0) begin
        errors++;
        $display("FAIL reset_k3: vs=%b de=%b data=%h, want all 0", bus3.win_vs, bus3.win_de, bus3.win_data);
      end
      checks++;
      if (bus5.win_vs !== 1'b0 || bus5.win_de !== 1'b0 || bus5.win_data !== '0) begin
        errors++;
        $display("FAIL reset_k5: vs=%b de=%b data=%h, want all 0", bus5.win_vs, bus5.win_de, bus5.win_data);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_vs_delay();
    int c0;
    drive(1'b1, 1'b0, 8'd0);
    c0 = cyc;
    drive(1'b0, 1'b0, 8'd0);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus3.win_vs !== (cyc == c0 + 2)) begin
        errors++;
        $display("FAIL vs_delay: cycle %0d win_vs=%b want %b", cyc - c0, bus3.win_vs, (cyc == c0 + 2));
      end
    end
    drain();
    $display("test_vs_delay done");
  endtask

  task automatic test_frame_k3();
    logic [199:0] d;
    clear_queues();
    run_frame(H, 1'b0, V, 1'b1, 0);
    drain();
    checks++;
    if (obs3.size() !== 24) begin
      errors++; $display("FAIL k3_count: got %0d pulses, want 24", obs3.size());
    end
    foreach (exp3[i]) if (i < obs3.size()) begin
      checks++;
      if (obs3[i].data !== exp3[i].data || obs3[i].cyc !== exp3[i].cyc) begin
        errors++;
        $display("FAIL k3_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs3[i].data, obs3[i].cyc, exp3[i].data, exp3[i].cyc);
      end
    end
    if (obs3.size() > 0) begin
      d = obs3[0].data;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (d[(i*3+j)*8 +: 8] !== 8'(i * 16 + j)) begin
            errors++;
            $display("FAIL k3_first_e%0d%0d: got %h want %h", i, j, d[(i*3+j)*8 +: 8], 8'(i * 16 + j));
          end
        end
      d = obs3[obs3.size() - 1].data;
      checks++;
      if (d[4*8 +: 8] !== 8'h46) begin
        errors++; $display("FAIL k3_last_centre: got %h want 46", d[4*8 +: 8]);
      end
    end
    $display("test_frame_k3 done: %0d pulses", obs3.size());
  endtask

  task automatic test_frame_k5();
    logic [199:0] d;
    clear_queues();
    run_frame(H, 1'b0, V, 1'b1, 0);
    drain();
    checks++;
    if (obs5.size() !== 8) begin
      errors++; $display("FAIL k5_count: got %0d pulses, want 8", obs5.size());
    end
    foreach (exp5[i]) if (i < obs5.size()) begin
      checks++;
      if (obs5[i].data !== exp5[i].data || obs5[i].cyc !== exp5[i].cyc) begin
        errors++;
        $display("FAIL k5_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs5[i].data, obs5[i].cyc, exp5[i].data, exp5[i].cyc);
      end
    end
    if (obs5.size() > 0) begin
      d = obs5[0].data;
      checks++;
      if (d[24*8 +: 8] !== 8'h44) begin
        errors++; $display("FAIL k5_first_e44: got %h want 44", d[24*8 +: 8]);
      end
      checks++;
      if (d[7:0] !== 8'h00) begin
        errors++; $display("FAIL k5_first_e00: got %h want 00", d[7:0]);
      end
    end
    $display("test_frame_k5 done: %0d pulses", obs5.size());
  endtask

  task automatic test_stalls();
    clear_queues();
    run_frame(H, 1'b1, V, 1'b1, int'($urandom_range(0, 255)));
    drain();
    checks++;
    if (obs3.size() !== exp3.size()) begin
      errors++; $display("FAIL stall_k3_count: got %0d want %0d", obs3.size(), exp3.size());
    end
    foreach (exp3[i]) if (i < obs3.size()) begin
      checks++;
      if (obs3[i].data !== exp3[i].data || obs3[i].cyc !== exp3[i].cyc) begin
        errors++;
        $display("FAIL stall_k3_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs3[i].data, obs3[i].cyc, exp3[i].data, exp3[i].cyc);
      end
    end
    checks++;
    if (obs5.size() !== exp5.size()) begin
      errors++; $display("FAIL stall_k5_count: got %0d want %0d", obs5.size(), exp5.size());
    end
    foreach (exp5[i]) if (i < obs5.size()) begin
      checks++;
      if (obs5[i].data !== exp5[i].data || obs5[i].cyc !== exp5[i].cyc) begin
        errors++;
        $display("FAIL stall_k5_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs5[i].data, obs5[i].cyc, exp5[i].data, exp5[i].cyc);
      end
    end
    $display("test_stalls done: %0d/%0d pulses", obs3.size(), obs5.size());
  endtask

  task automatic test_long_lines();
    clear_queues();
    run_frame(10, 1'b0, V, 1'b1, int'($urandom_range(0, 255)));
    drain();
    checks++;
    if (obs3.size() !== 24) begin
      errors++; $display("FAIL long_k3_count: got %0d want 24", obs3.size());
    end
    foreach (exp3[i]) if (i < obs3.size()) begin
      checks++;
      if (obs3[i].data !== exp3[i].data || obs3[i].cyc !== exp3[i].cyc) begin
        errors++;
        $display("FAIL long_k3_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs3[i].data, obs3[i].cyc, exp3[i].data, exp3[i].cyc);
      end
    end
    checks++;
    if (obs5.size() !== 8) begin
      errors++; $display("FAIL long_k5_count: got %0d want 8", obs5.size());
    end
    $display("test_long_lines done: %0d pulses", obs3.size());
  endtask

  task automatic test_back_to_back();
    clear_queues();
    run_frame(H, 1'b0, V, 1'b0, int'($urandom_range(0, 127)));
    run_frame(H, 1'b0, V, 1'b1, int'($urandom_range(128, 255)));
    drain();
    checks++;
    if (obs3.size() !== 48) begin
      errors++; $display("FAIL b2b_k3_count: got %0d want 48", obs3.size());
    end
    foreach (exp3[i]) if (i < obs3.size()) begin
      checks++;
      if (obs3[i].data !== exp3[i].data || obs3[i].cyc !== exp3[i].cyc) begin
        errors++;
        $display("FAIL b2b_k3_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs3[i].data, obs3[i].cyc, exp3[i].data, exp3[i].cyc);
      end
    end
    checks++;
    if (obs5.size() !== exp5.size()) begin
      errors++; $display("FAIL b2b_k5_count: got %0d want %0d", obs5.size(), exp5.size());
    end
    foreach (exp5[i]) if (i < obs5.size()) begin
      checks++;
      if (obs5[i].data !== exp5[i].data || obs5[i].cyc !== exp5[i].cyc) begin
        errors++;
        $display("FAIL b2b_k5_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs5[i].data, obs5[i].cyc, exp5[i].data, exp5[i].cyc);
      end
    end
    $display("test_back_to_back done: %0d/%0d pulses", obs3.size(), obs5.size());
  endtask

  task automatic test_mid_reset();
    int off = int'($urandom_range(0, 255));
    clear_queues();
    run_frame(H, 1'b0, 3, 1'b1, off);
    for (int c = 0; c < 4; c++) drive_pixel(3, c, off);
    @(posedge clk); #1;
    rst_n = 1'b0; pre_de = 1'b0; pre_vs = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus3.win_vs !== 1'b0 || bus3.win_de !== 1'b0 || bus3.win_data !== '0) begin
        errors++;
        $display("FAIL midrst_k3_out: vs=%b de=%b data=%h, want all 0", bus3.win_vs, bus3.win_de, bus3.win_data);
      end
      checks++;
      if (bus5.win_vs !== 1'b0 || bus5.win_de !== 1'b0 || bus5.win_data !== '0) begin
        errors++;
        $display("FAIL midrst_k5_out: vs=%b de=%b data=%h, want all 0", bus5.win_vs, bus5.win_de, bus5.win_data);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_queues();
    run_frame(H, 1'b0, V, 1'b1, int'($urandom_range(0, 255)));
    drain();
    checks++;
    if (obs3.size() !== 24) begin
      errors++; $display("FAIL midrst_k3_count: got %0d want 24", obs3.size());
    end
    foreach (exp3[i]) if (i < obs3.size()) begin
      checks++;
      if (obs3[i].data !== exp3[i].data || obs3[i].cyc !== exp3[i].cyc) begin
        errors++;
        $display("FAIL midrst_k3_win%0d: got %h at cycle %0d, want %h at cycle %0d",
                 i, obs3[i].data, obs3[i].cyc, exp3[i].data, exp3[i].cyc);
      end
    end
    $display("test_mid_reset done: %0d pulses", obs3.size());
  endtask

`ifdef MATRIX_WIN_COORD_EN
  task automatic test_coord();
    clear_queues();
    run_frame(H, 1'b1, V, 1'b1, int'($urandom_range(0, 255)));
    drain();
    checks++;
    if (obs3.size() !== 24) begin
      errors++; $display("FAIL coord_count: got %0d want 24", obs3.size());
    end
    foreach (exp3[i]) if (i < obs3.size()) begin
      checks++;
      if (obs3[i].x !== exp3[i].x || obs3[i].y !== exp3[i].y) begin
        errors++;
        $display("FAIL coord_xy%0d: got (%0d,%0d) want (%0d,%0d)", i, obs3[i].x, obs3[i].y, exp3[i].x, exp3[i].y);
      end
    end
    if (obs3.size() > 0) begin
      checks++;
      if (obs3[0].x !== 1 || obs3[0].y !== 1) begin
        errors++; $display("FAIL coord_first: got (%0d,%0d) want (1,1)", obs3[0].x, obs3[0].y);
      end
      checks++;
      if (obs3[obs3.size()-1].x !== 6 || obs3[obs3.size()-1].y !== 4) begin
        errors++;
        $display("FAIL coord_last: got (%0d,%0d) want (6,4)", obs3[obs3.size()-1].x, obs3[obs3.size()-1].y);
      end
    end
    $display("test_coord done: %0d pulses", obs3.size());
  endtask
`endif

  initial begin
    test_reset();
    test_vs_delay();
    test_frame_k3();
    test_frame_k5();
    test_stalls();
    test_long_lines();
    test_back_to_back();
    test_mid_reset();
`ifdef MATRIX_WIN_COORD_EN
    test_coord();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_win_gen.md
MATRIX_WIN_GEN -- requirements
Module: matrix_win_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel bit width.
REQ-002 SHALL have parameter KSIZE, default 3, meaning window edge length; legal values are 3 and 5 only.
REQ-003 SHALL have parameter IMG_HDISP, default 1280, meaning active pixels per line.
REQ-004 SHALL have parameter IMG_VDISP, default 720, meaning active lines per frame.
REQ-005 SHALL have port clk, input, 1 bit: pixel clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pre_vs, input, 1 bit: frame sync, active high, high before the first line.
REQ-008 SHALL have port pre_de, input, 1 bit: pixel valid, high for each active pixel of a line.
REQ-009 SHALL have port pre_data, input, DATA_W bits: pixel value.
REQ-010 SHALL have port win_vs, output, 1 bit: pre_vs delayed by 2 cycles.
REQ-011 SHALL have port win_de, output, 1 bit: window valid strobe.
REQ-012 SHALL have port win_data, output, KSIZE*KSIZE*DATA_W bits: window; element (i,j) at bits [(i*KSIZE+j+1)*DATA_W-1 : (i*KSIZE+j)*DATA_W]; i=0 is the oldest row; j=0 is the leftmost column.

Function
REQ-013 SHALL keep a column counter col: increments on each accepted pixel; clears on the pre_de falling edge and on the pre_vs rising edge.
REQ-014 SHALL keep a row counter row: increments on the pre_de falling edge; clears on the pre_vs rising edge; saturates at IMG_VDISP.
REQ-015 SHALL treat a pixel as accepted only when pre_de=1, col<IMG_HDISP and row<IMG_VDISP; all other pixels are dropped with no state change.
REQ-016 SHALL hold KSIZE-1 line buffers, each IMG_HDISP deep and addressed by col, with read-before-write, cascaded so that buffer k holds row-(k+1).
REQ-017 SHALL, on each accepted pixel, shift every window row left by one and load column KSIZE-1 from the line buffers and pre_data (row i receives line row-(KSIZE-1-i)).
REQ-018 SHALL update win_data exactly 2 cycles after the accepting clock edge and hold it otherwise.
REQ-019 SHALL assert win_de for one cycle, 2 cycles after an accepted pixel, only when col>=KSIZE-1 and row>=KSIZE-1 at acceptance (no border windows emitted).
REQ-020 SHALL make element (KSIZE-1,KSIZE-1) equal to the accepted pixel (col,row), so the window centre is (col-R,row-R) where R=(KSIZE-1)/2.
REQ-021 SHALL emit exactly (IMG_HDISP-KSIZE+1)*(IMG_VDISP-KSIZE+1) win_de pulses per conforming frame.
REQ-022 SHALL handle back-to-back frames, where pre_vs rises immediately after the last pixel, with no stale window emitted in the new frame.
REQ-023 SHALL handle gaps of pre_de inside a line (pixel stalls) by holding all state.

Reset
REQ-024 SHALL, while rst_n=0, drive win_vs=0, win_de=0, win_data=0 and clear col, row and all pipeline registers; line buffer contents need not be cleared.
REQ-025 SHALL, after reset mid-frame, emit no win_de until row>=KSIZE-1 and col>=KSIZE-1 of the counted position are reached again.

Configuration
REQ-026 SHALL, when macro MATRIX_WIN_COORD_EN is defined, add outputs win_x and win_y (12 bits each, reset 0), aligned with win_de, carrying the window centre (col-R, row-R).
REQ-027 SHALL, when MATRIX_WIN_COORD_EN is undefined, omit win_x and win_y and their registers, with all other behaviour identical.

Verification (IMG_HDISP=8, IMG_VDISP=6, DATA_W=8, pixel=row*16+col)
REQ-028 SHALL verify KSIZE=3, one frame -> 24 win_de pulses; first window rows {00,01,02},{10,11,12},{20,21,22}; last centre pixel 0x46.
REQ-029 SHALL verify KSIZE=5, one frame -> 8 win_de pulses; first window element (4,4)=0x44, element (0,0)=0x00.
REQ-030 SHALL verify random 1-3 cycle pre_de stalls inside lines -> win_data sequence identical to the no-stall run, and win_de latency from the accepting edge always 2 cycles.
REQ-031 SHALL verify lines of 10 pixels -> pixels at col 8 and 9 ignored; 24 pulses with unchanged data.
REQ-032 SHALL verify rst_n pulse during row 3, then restart of the frame -> all outputs 0 during reset; next frame produces 24 correct pulses.
REQ-033 SHALL verify, with MATRIX_WIN_COORD_EN defined, KSIZE=3 -> first pulse has win_x=1, win_y=1; last pulse has win_x=6, win_y=4.
